// File: rtl/rx_fsm.sv
// Flit receiver: buffers incoming flits in a credit-managed FIFO and writes
// each packet into its per-ID slot of the rx buffer.
module rx_fsm #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] RX_BASE_ADDR = 32'h2000,
  parameter int unsigned SLOT_WORDS   = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [39:0] flit_in,
  input  logic        flit_valid,
  output logic        credit_return,
  output logic        wen,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        request_stall,
  output logic        rx_done,
  output logic [1:0]  rx_done_id,
  output logic [4:0]  rx_done_req,
  output logic [7:0]  rx_done_len,
  output logic        overflow_err
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [31:0] SLOT_BYTES = 32'(SLOT_WORDS * 4);
  localparam logic [31:0] SLOT_LIM   = 32'(SLOT_WORDS);
  localparam logic [AW:0] PTR_ONE    = 1;
  localparam logic [AW:0] PTR_FULL   = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BODY,
    DONE
  } state_t;

  state_t      state;
  logic [39:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  cnt;
  logic [7:0]  len_q;
  logic [1:0]  id_q;
  logic [4:0]  req_q;
  logic [31:0] base_q;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [39:0] head;
  logic [1:0]  hd_id;
  logic [4:0]  hd_req;
  logic [31:0] hd_pay;
  logic [7:0]  hd_len;
  logic [31:0] hdr_addr;
  logic [31:0] body_addr;
  logic        in_slot;
  logic        long_hdr;
  logic        unused_vc;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ((wr_ptr ^ rd_ptr) == PTR_FULL);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign unused_vc = head[39];
  assign hd_id     = head[38:37];
  assign hd_req    = head[36:32];
  assign hd_pay    = head[31:0];
  assign hd_len    = (hd_pay[7:0] == 8'd0) ? 8'd1 : hd_pay[7:0];
  assign hdr_addr  = RX_BASE_ADDR + 32'(hd_id) * SLOT_BYTES;
  assign body_addr = base_q + {22'd0, cnt, 2'd0};
  assign in_slot   = ({24'd0, cnt} < SLOT_LIM);
  assign long_hdr  = ({24'd0, hd_len} > SLOT_LIM);
  // a pop at full frees the slot the same-cycle push lands in
  assign push      = flit_valid && (!full || pop);

  always_comb begin
    wen   = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    pop   = 1'b0;
    unique case (state)
      HEADER: begin
        if (!empty) begin
          wen   = 1'b1;
          addr  = hdr_addr;
          wdata = hd_pay;
          pop   = !request_stall;
        end
      end
      BODY: begin
        if (!empty) begin
          wen   = in_slot;
          addr  = in_slot ? body_addr : 32'd0;
          wdata = in_slot ? hd_pay : 32'd0;
          pop   = !request_stall || !in_slot;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= flit_in;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= 8'd0;
      len_q         <= 8'd0;
      id_q          <= 2'd0;
      req_q         <= 5'd0;
      base_q        <= 32'd0;
      credit_return <= 1'b0;
      rx_done       <= 1'b0;
      rx_done_id    <= 2'd0;
      rx_done_req   <= 5'd0;
      rx_done_len   <= 8'd0;
      overflow_err  <= 1'b0;
    end else begin
      credit_return <= pop;
      rx_done       <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (flit_valid && full && !pop) overflow_err <= 1'b1;
      unique case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (!empty) state <= HEADER;
        end
        HEADER: begin
          if (pop) begin
            id_q   <= hd_id;
            req_q  <= hd_req;
            len_q  <= hd_len;
            base_q <= hdr_addr;
            if (long_hdr) overflow_err <= 1'b1;
            if (hd_len == 8'd1) begin
              state       <= DONE;
              rx_done     <= 1'b1;
              rx_done_id  <= hd_id;
              rx_done_req <= hd_req;
              rx_done_len <= hd_len;
            end else begin
              state <= BODY;
              cnt   <= 8'd1;
            end
          end
        end
        BODY: begin
          if (pop) begin
            if (cnt == len_q - 8'd1) begin
              state       <= DONE;
              rx_done     <= 1'b1;
              rx_done_id  <= id_q;
              rx_done_req <= req_q;
              rx_done_len <= len_q;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_fsm.sv
// Scoreboard bench for rx_fsm: expected writes and completions are queued
// at stimulus time and matched by a negedge monitor.
module tb_rx_fsm;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [39:0] flit_in;
  logic        flit_valid;
  logic        credit_return;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        request_stall;
  logic        rx_done;
  logic [1:0]  rx_done_id;
  logic [4:0]  rx_done_req;
  logic [7:0]  rx_done_len;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int returned = 0;
  int wr_cnt = 0;
  logic [63:0] exp_wr[$];
  logic [14:0] exp_done[$];

  rx_fsm dut (
    .clk(clk),
    .n_rst(n_rst),
    .flit_in(flit_in),
    .flit_valid(flit_valid),
    .credit_return(credit_return),
    .wen(wen),
    .addr(addr),
    .wdata(wdata),
    .request_stall(request_stall),
    .rx_done(rx_done),
    .rx_done_id(rx_done_id),
    .rx_done_req(rx_done_req),
    .rx_done_len(rx_done_len),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slot(input logic [1:0] id);
    return 32'h2000 + 32'(id) * 32'd256;
  endfunction

  task automatic mon_loop();
    logic [63:0] e;
    logic [14:0] d;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (credit_return) returned++;
        if (wen && !request_stall) begin
          wr_cnt++;
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected addr=%h data=%h required none",
                     addr, wdata);
          end else begin
            e = exp_wr.pop_front();
            if ({addr, wdata} !== e) begin
              errors++;
              $display("FAIL wr addr=%h data=%h required addr=%h data=%h",
                       addr, wdata, e[63:32], e[31:0]);
            end
          end
        end
        if (rx_done) begin
          checks++;
          if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected id=%0d req=%0d len=%0d",
                     rx_done_id, rx_done_req, rx_done_len);
          end else begin
            d = exp_done.pop_front();
            if ({rx_done_id, rx_done_req, rx_done_len} !== d) begin
              errors++;
              $display("FAIL done id=%0d req=%0d len=%0d required %0d %0d %0d",
                       rx_done_id, rx_done_req, rx_done_len,
                       d[14:13], d[12:8], d[7:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic push_flit(input logic [39:0] f);
    int w = 0;
    while (DEPTH - pushed + returned <= 0 && w <= 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w > 200) begin
      checks++;
      errors++;
      $display("FAIL credit_wait waited=%0d required <=200", w);
    end
    flit_valid = 1'b1;
    flit_in    = f;
    pushed++;
    @(posedge clk); #1;
    flit_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] id, input logic [4:0] req,
                          input logic [31:0] hpay);
    logic [7:0]  leff;
    logic [31:0] p;
    leff = (hpay[7:0] == 8'd0) ? 8'd1 : hpay[7:0];
    exp_done.push_back({id, req, leff});
    exp_wr.push_back({slot(id), hpay});
    push_flit({1'b0, id, req, hpay});
    for (int k = 1; k < int'(leff); k++) begin
      p = $urandom;
      if (k < 64) exp_wr.push_back({slot(id) + 32'(k * 4), p});
      push_flit({1'($urandom), 2'($urandom), 5'($urandom), p});
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (w >= 2000) begin
      errors++;
      $display("FAIL %s_drain wr_left=%0d done_left=%0d required 0",
               name, exp_wr.size(), exp_done.size());
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({wen, addr, wdata, credit_return, rx_done, rx_done_id,
         rx_done_req, rx_done_len, overflow_err} !== '0) begin
      errors++;
      $display("FAIL %s outs wen=%b addr=%h wdata=%h cr=%b done=%b id=%0d req=%0d len=%0d ovf=%b required all 0",
               name, wen, addr, wdata, credit_return, rx_done, rx_done_id,
               rx_done_req, rx_done_len, overflow_err);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    flit_valid = 1'b0;
    flit_in = '0;
    request_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("post_reset");
  endtask

  task automatic test_basic();
    int c0 = returned;
    int w0 = wr_cnt;
    send_pkt(2'd1, 5'd3, 32'd3);
    @(negedge clk);
    checks++;
    if (rx_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_early t3 got %b required 0", rx_done);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rx_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_early t4 got %b required 0", rx_done);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rx_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_time got %b required 1", rx_done);
    end
    wait_drain("basic");
    checks++;
    if (wr_cnt - w0 != 3 || returned - c0 != 3) begin
      errors++;
      $display("FAIL basic_counts writes=%0d credits=%0d required 3 3",
               wr_cnt - w0, returned - c0);
    end
    checks++;
    if ({rx_done_id, rx_done_req, rx_done_len} !== {2'd1, 5'd3, 8'd3}) begin
      errors++;
      $display("FAIL basic_hold id=%0d req=%0d len=%0d required 1 3 3",
               rx_done_id, rx_done_req, rx_done_len);
    end
  endtask

  task automatic test_len0();
    send_pkt(2'd2, 5'd17, 32'hCAFE_0000);
    @(negedge clk);
    checks++;
    if (wen !== 1'b0) begin
      errors++;
      $display("FAIL len0_wen_t1 got %b required 0", wen);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (wen !== 1'b1 || addr !== 32'h2200) begin
      errors++;
      $display("FAIL len0_hdr_t2 wen=%b addr=%h required 1 00002200",
               wen, addr);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rx_done !== 1'b1 || rx_done_len !== 8'd1) begin
      errors++;
      $display("FAIL len0_done done=%b len=%0d required 1 1",
               rx_done, rx_done_len);
    end
    wait_drain("len0");
  endtask

  task automatic test_stall();
    logic [63:0] held;
    send_pkt(2'd0, 5'd5, 32'd3);
    request_stall = 1'b1;
    held = exp_wr[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (wen !== 1'b1 || {addr, wdata} !== held) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d wen=%b addr=%h data=%h required 1 %h %h",
                 i, wen, addr, wdata, held[63:32], held[31:0]);
      end
      if (i > 0) begin
        checks++;
        if (credit_return !== 1'b0) begin
          errors++;
          $display("FAIL stall_credit cyc=%0d got %b required 0",
                   i, credit_return);
        end
      end
      @(posedge clk); #1;
    end
    request_stall = 1'b0;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (rx_done !== 1'b0) begin
      errors++;
      $display("FAIL stall_done_early got %b required 0", rx_done);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rx_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done_time got %b required 1", rx_done);
    end
    wait_drain("stall");
  endtask

  task automatic test_back_to_back();
    send_pkt(2'd3, 5'd1, 32'd1);
    send_pkt(2'd1, 5'd30, 32'h0000_1204);
    send_pkt(2'd0, 5'd8, 32'd2);
    wait_drain("b2b");
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovf got %b required 0", overflow_err);
    end
  endtask

  task automatic test_long();
    int c0 = returned;
    int w0 = wr_cnt;
    send_pkt(2'd2, 5'd9, 32'h0000_AB46);
    wait_drain("long");
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL long_ovf got %b required 1", overflow_err);
    end
    checks++;
    if (wr_cnt - w0 != 64 || returned - c0 != 70) begin
      errors++;
      $display("FAIL long_counts writes=%0d pops=%0d required 64 70",
               wr_cnt - w0, returned - c0);
    end
    checks++;
    if (rx_done_len !== 8'd70) begin
      errors++;
      $display("FAIL long_len got %0d required 70", rx_done_len);
    end
  endtask

  task automatic test_reset_mid();
    send_pkt(2'd1, 5'd2, 32'd6);
    checks++;
    if (wen !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_body wen=%b required 1", wen);
    end
    n_rst = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_wr.delete();
    exp_done.delete();
    pushed = 0;
    returned = 0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    send_pkt(2'd3, 5'd7, 32'd2);
    wait_drain("mid_fresh");
    checks++;
    if ({rx_done_id, rx_done_req, rx_done_len, overflow_err} !==
        {2'd3, 5'd7, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL mid_fresh id=%0d req=%0d len=%0d ovf=%b required 3 7 2 0",
               rx_done_id, rx_done_req, rx_done_len, overflow_err);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] p;
    int w0 = wr_cnt;
    request_stall = 1'b1;
    exp_done.push_back({2'd0, 5'd1, 8'd8});
    exp_wr.push_back({slot(2'd0), 32'd8});
    flit_valid = 1'b1;
    flit_in = {1'b0, 2'd0, 5'd1, 32'd8};
    @(posedge clk); #1;
    for (int k = 1; k < 8; k++) begin
      p = $urandom;
      exp_wr.push_back({slot(2'd0) + 32'(k * 4), p});
      flit_in = {1'b1, 2'd3, 5'd0, p};
      @(posedge clk); #1;
    end
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL full_ovf_early got %b required 0", overflow_err);
    end
    flit_in = {1'b0, 2'd3, 5'd4, 32'd1};
    @(posedge clk); #1;
    flit_valid = 1'b0;
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL full_ovf got %b required 1", overflow_err);
    end
    repeat (3) @(posedge clk);
    #1;
    request_stall = 1'b0;
    wait_drain("full");
    checks++;
    if (overflow_err !== 1'b1 || wr_cnt - w0 != 8) begin
      errors++;
      $display("FAIL full_sticky ovf=%b writes=%0d required 1 8",
               overflow_err, wr_cnt - w0);
    end
  endtask

  initial begin
    fork
      mon_loop();
    join_none
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_back_to_back();
    test_long();
    test_reset_mid();
    test_fifo_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
